// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding,
// access-size decode and lane-select helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Bit 2 of funct3 only selects zero-extension; the low bits give the size.
    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    // Halves ignore offset bit 0, words ignore both bits: misaligned
    // accesses that reach the lane logic are thereby aligned down.
    function automatic logic [4:0] lane_shift(input lsu_size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return {off, 3'b000};
            SZ_HALF: return {off[1], 4'b0000};
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core-side request/response handshake plus data-memory port of the LSU.
// slave = the LSU itself, master = the core and memory around it.
interface lsu_mem_ctrl_if #(
    parameter int XLEN = 32
);

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wd;
    logic [XLEN-1:0] mem_rd;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wd
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wd
    );

endinterface

// File: rtl/lsu_lane_unit.sv
// Combinational byte/half lane logic: load extract with sign/zero extension
// and store merge of new data into the previously read word.
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_old,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    lsu_size_e   w_size;
    logic [4:0]  w_sh;
    logic [15:0] w_lane;
    logic        w_sext;

    assign w_size = f3_size(i_funct3);
    assign w_sh   = lane_shift(w_size, i_off);
    assign w_lane = 16'(i_word >> w_sh);
    assign w_sext = ~i_funct3[2];

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_load  = i_word;
        o_merge = i_wdata;
        case (w_size)
            SZ_BYTE: begin
                o_load  = {{24{w_sext & w_lane[7]}}, w_lane[7:0]};
                o_merge = (i_old & ~(BYTE_MASK << w_sh)) | ((i_wdata & BYTE_MASK) << w_sh);
            end
            SZ_HALF: begin
                o_load  = {{16{w_sext & w_lane[15]}}, w_lane};
                o_merge = (i_old & ~(HALF_MASK << w_sh)) | ((i_wdata & HALF_MASK) << w_sh);
            end
            default: begin
                o_load  = i_word;
                o_merge = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// RV32 load/store initiator: turns byte/half/word requests into aligned word
// accesses (read-modify-write for sub-word stores). Optional misaligned-access
// trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic           CLK,
    input logic           RST,
    lsu_mem_ctrl_if.slave lsu_bus
);

    lsu_state_e      r_state;
    lsu_state_e      w_next;

    logic            r_we;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_word;
    logic [XLEN-1:0] r_resp_rdata;
    logic            r_err;

    logic            w_accept;
    logic            w_misalign;
    logic            w_err;
    logic            w_store_word;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_merge;

    assign w_accept     = (r_state == IDLE) && lsu_bus.req_valid;
    assign w_store_word = lsu_bus.req_we && (f3_size(lsu_bus.req_funct3) == SZ_WORD);

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        w_misalign = 1'b0;
        case (f3_size(lsu_bus.req_funct3))
            SZ_HALF: w_misalign = lsu_bus.req_addr[0];
            SZ_WORD: w_misalign = |lsu_bus.req_addr[1:0];
            default: w_misalign = 1'b0;
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err = w_misalign || !f3_legal(lsu_bus.req_funct3);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (lsu_bus.req_valid) begin
                    if (w_err)             w_next = RESP;
                    else if (w_store_word) w_next = WRITE;
                    else                   w_next = READ;
                end
            end
            READ:    w_next = r_we ? WRITE : RESP;
            WRITE:   w_next = RESP;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_word       <= '0;
            r_resp_rdata <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we     <= lsu_bus.req_we;
                r_funct3 <= lsu_bus.req_funct3;
                r_addr   <= lsu_bus.req_addr;
                r_wdata  <= lsu_bus.req_wdata;
                r_err    <= w_err;
            end
            if (r_state == READ) begin
                r_word <= lsu_bus.mem_rd;
                if (!r_we) r_resp_rdata <= w_load;
            end
        end
    end

    lsu_lane_unit u_lane (
        .i_word   (lsu_bus.mem_rd),
        .i_old    (r_word),
        .i_wdata  (r_wdata),
        .i_off    (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_load   (w_load),
        .o_merge  (w_merge)
    );

    // Memory port is driven only while an access is actually in progress.
    assign lsu_bus.req_ready  = (r_state == IDLE);
    assign lsu_bus.resp_valid = (r_state == RESP);
    assign lsu_bus.resp_err   = (r_state == RESP) && r_err;
    assign lsu_bus.resp_rdata = r_resp_rdata;
    assign lsu_bus.mem_we     = (r_state == WRITE);
    assign lsu_bus.mem_addr   = ((r_state == READ) || (r_state == WRITE)) ?
                                {r_addr[XLEN-1:2], 2'b00} : '0;
    assign lsu_bus.mem_wd     = (r_state == WRITE) ? w_merge : '0;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator between the core's execute stage and the word-addressed, word-aligned-only data memory (1-cycle write, combinational read).
- Converts RV32 LB/LH/LW/LBU/LHU/SB/SH/SW requests into aligned word accesses.
- Sub-word stores are done as read-modify-write; loads return byte/half extracted and sign- or zero-extended.
- Single outstanding request; valid/ready handshake on the core side.

Parameters:
- XLEN, 32, data and address width; only 32 is supported.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high.
- req_valid  in  1  core presents a request.
- req_ready  out  1  block can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle pulse when the access completes.
- resp_rdata  out  32  load result; held until the next response.
- resp_err  out  1  misalignment or illegal funct3; valid with resp_valid.
- mem_we  out  1  data-memory write enable.
- mem_addr  out  32  word-aligned byte address; bits [1:0] are always 00.
- mem_wd  out  32  data-memory write data.
- mem_rd  in  32  data-memory combinational read data.

Behaviour:
- Reset (RST high at an edge, any state):
  - state = IDLE, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_we = 0.
  - Latched request fields are cleared.
  - An in-flight RMW is abandoned; no write is issued after reset.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch we, funct3, addr, wdata.
  - If the request is erroneous (see Optional Feature) or funct3 is illegal: go to RESP with err = 1.
  - Else if store-word: go to WRITE.
  - Else: go to READ.
- READ:
  - mem_addr = {addr[31:2], 00}, mem_we = 0; capture mem_rd into the word register.
  - Load: extract the lane at addr[1:0] (byte) or addr[1] (half), sign- or zero-extend, register into resp_rdata, go to RESP.
  - Store: go to WRITE.
- WRITE:
  - mem_we = 1, mem_addr as in READ.
  - mem_wd = wdata for SW; otherwise the captured word with the addressed byte/half lane replaced by wdata[7:0] / wdata[15:0].
  - Next state RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle, then IDLE.
  - resp_rdata is unchanged for stores and errors.
  - resp_err = 1 only for errored requests, else 0.
- Latency, counted from the accept edge T to the resp_valid cycle:
  - LW/LB/LH/LBU/LHU: READ at T+1, resp_valid at T+2.
  - SW: WRITE at T+1, resp_valid at T+2.
  - SB/SH: READ at T+1, WRITE at T+2, resp_valid at T+3.
  - Throughput: next accept no earlier than the cycle after RESP.
- mem_we is asserted only in WRITE; mem_addr and mem_wd are 0 in IDLE and RESP.
- req_* changes while not in IDLE are ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a half with addr[0] = 1, or a word with addr[1:0] != 00, gives resp_err = 1 after the 1-cycle error path (resp_valid at T+1). There is no memory access and resp_rdata is unchanged.
- Undefined: misaligned addresses are silently aligned down (half clears bit 0, word clears bits [1:0]) and the access proceeds normally. Only illegal funct3 raises resp_err.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encoding: IDLE = 0, READ = 1, WRITE = 2, RESP = 3.
  - Lane-select helper constants.
- Sub-module lsu_lane_unit is combinational and provides:
  - load extract/extend from (word, addr[1:0], funct3);
  - store merge from (old word, wdata, addr[1:0], funct3).
- The FSM and registers stay in lsu_mem_ctrl.

Test Plan:
1. Preload mem[0x10] = 0x8899AABB; LB at addr 0x12 -> resp_rdata = 0xFFFFFF99 at T+2. LBU at the same address -> 0x00000099.
2. SH with wdata = 0x00001234 at addr 0x22, mem[0x20] = 0xDEADBEEF -> WRITE at T+2 with mem_wd = 0x1234BEEF, resp_valid at T+3. A following LW at 0x20 returns 0x1234BEEF.
3. SW with 0xCAFEF00D at 0x40 -> mem_we high only at T+1, no READ cycle, resp_valid at T+2, resp_err = 0.
4. LW at 0x41 with LSU_MISALIGN_TRAP_EN -> resp_err = 1 at T+1, mem_we never asserts. Without the macro -> reads 0x40, resp_err = 0.
5. SB accepted, RST asserted in the READ cycle -> mem_we never asserts, target word unchanged, all outputs 0, req_ready = 1 the cycle after reset.
6. funct3 = 011 load -> resp_err = 1, no memory access. Back-to-back req_valid held high is accepted only in IDLE; req_ready = 0 in READ, WRITE and RESP.
